// File: rtl/memory_stage.sv
// Memory pipeline stage: scalar/vector loads and stores over a req/ack port, stalling upstream while busy.
// Optional feature macro MEM_TIMEOUT_EN adds a BUSY watchdog that aborts the access and sets sticky MEM_ERR.

module memory_stage #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [115:0]      PIPELINE_E,
    output logic [111:0]      PIPELINE_M,
    output logic              STALL,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_WDATA,
    input  logic [31:0]       MEM_RDATA,
    input  logic              MEM_ACK,
    output logic              MEM_ERR
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [111:0]      r_pipeM;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_loadBuf;

    logic              w_condOk;
    logic              w_memWrite;
    logic              w_memRead;
    logic              w_vecSel;
    logic              w_memOp;
    logic              w_timeout;
    logic [2:0]        w_ctrl;
    logic [10:0]       w_wbDest;
    logic [65:0]       w_passLow;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;

    assign w_condOk   = PIPELINE_E[115];
    assign w_memWrite = PIPELINE_E[114];
    assign w_memRead  = PIPELINE_E[113];
    assign w_vecSel   = PIPELINE_E[112];
    assign w_memOp    = w_condOk & (w_memWrite | w_memRead);

    // A squashed instruction keeps its data fields but loses all writeback enables.
    assign w_ctrl     = w_condOk ? PIPELINE_E[111:109] : 3'b000;
    assign w_wbDest   = PIPELINE_E[108:98];
    assign w_passLow  = PIPELINE_E[65:0];
    assign w_addr     = PIPELINE_E[ADDR_W+35:36];
    assign w_wdata    = w_vecSel ? PIPELINE_E[31:0] : PIPELINE_E[97:66];

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_toCount;
    logic             r_err;

    // The counter restarts whenever the FSM is IDLE, so each access gets a fresh budget.
    assign w_timeout = (r_state == BUSY) && !MEM_ACK &&
                       (r_toCount == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_toCount <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state != BUSY) begin
                r_toCount <= '0;
            end else if (!MEM_ACK) begin
                r_toCount <= r_toCount + CNT_W'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign MEM_ERR = r_err;
`else
    assign w_timeout = 1'b0;
    assign MEM_ERR   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        STALL       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_memOp) begin
                    STALL       = 1'b1;
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                STALL = 1'b1;
                if (MEM_ACK || w_timeout) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (RST) begin
            STALL = 1'b0;
        end
    end

    // Bubbles leave the stage while an access is in flight; the real word goes out in DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pipeM   <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_loadBuf <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_loadBuf <= '0;
                    if (w_memOp) begin
                        r_pipeM <= '0;
                        r_req   <= 1'b1;
                        r_we    <= w_memWrite;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                    end else begin
                        r_pipeM <= {w_ctrl, w_wbDest, 32'h0, w_passLow};
                    end
                end
                BUSY: begin
                    r_pipeM <= '0;
                    if (MEM_ACK) begin
                        r_req     <= 1'b0;
                        r_loadBuf <= r_we ? 32'h0 : MEM_RDATA;
                    end else if (w_timeout) begin
                        r_req     <= 1'b0;
                        r_loadBuf <= '0;
                    end
                end
                DONE: begin
                    r_pipeM <= {w_ctrl, w_wbDest, r_loadBuf, w_passLow};
                end
                default: begin
                    r_pipeM <= '0;
                end
            endcase
        end
    end

    assign PIPELINE_M = r_pipeM;
    assign MEM_REQ    = r_req;
    assign MEM_WE     = r_we;
    assign MEM_ADDR   = r_addr;
    assign MEM_WDATA  = r_wdata;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus random back-to-back traffic
// compared against a field-level reference model.

module tb_memory_stage;

    localparam int ADDR_W     = 16;
    localparam int BUSY_LIMIT = 200;

    typedef struct packed {
        logic        condOk;
        logic        memWrite;
        logic        memRead;
        logic        vecSel;
        logic        regWrS;
        logic        regWrV;
        logic        memToReg;
        logic [2:0]  wbMisc;
        logic [7:0]  dest;
        logic [31:0] storeData;
        logic [31:0] sResult;
        logic [1:0]  pass2;
        logic [31:0] vResult;
    } exWord_t;

    logic              CLK;
    logic              RST;
    logic [115:0]      PIPELINE_E;
    logic [111:0]      PIPELINE_M;
    logic              STALL;
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_WDATA;
    logic [31:0]       MEM_RDATA;
    logic              MEM_ACK;
    logic              MEM_ERR;

    int nCompared;
    int nMismatched;

    memory_stage #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .PIPELINE_E(PIPELINE_E),
        .PIPELINE_M(PIPELINE_M),
        .STALL(STALL),
        .MEM_REQ(MEM_REQ),
        .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA),
        .MEM_ACK(MEM_ACK),
        .MEM_ERR(MEM_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic isMemOp(exWord_t e);
        return e.condOk && (e.memWrite || e.memRead);
    endfunction

    // Writeback word as the instruction should look once it leaves the stage.
    function automatic logic [111:0] expectM(exWord_t e, logic [31:0] rdata);
        logic [31:0] load;
        logic [2:0]  ctrl;
        load = (isMemOp(e) && !e.memWrite) ? rdata : 32'h0;
        ctrl = e.condOk ? {e.regWrS, e.regWrV, e.memToReg} : 3'b000;
        return {ctrl, e.wbMisc, e.dest, load, e.sResult, e.pass2, e.vResult};
    endfunction

    function automatic exWord_t randomWord();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return exWord_t'(r[115:0]);
    endfunction

    // Plays one instruction through the stage with a memory that acks in BUSY cycle ackDelay
    // (0 = never); starts and ends 1 time unit after a rising edge with the FSM idle.
    task automatic runOp(input exWord_t e, input int ackDelay, input logic [31:0] rdata,
                         output int stallCycles, output int cycles, output logic reqSeen,
                         output logic weSeen, output logic [ADDR_W-1:0] addrSeen,
                         output logic [31:0] wdataSeen, output logic bubbleOk,
                         output logic holdOk, output logic [111:0] pmOut,
                         output logic errSeen, output logic finished);
        stallCycles = 0;
        cycles      = 0;
        reqSeen     = 1'b0;
        weSeen      = 1'b0;
        addrSeen    = '0;
        wdataSeen   = '0;
        bubbleOk    = 1'b1;
        holdOk      = 1'b1;
        finished    = 1'b0;
        errSeen     = 1'b0;
        PIPELINE_E  = e;
        MEM_ACK     = 1'b0;
        MEM_RDATA   = $urandom();
        #1;
        if (STALL) stallCycles++;
        @(posedge CLK); #1;
        cycles++;
        if (MEM_REQ) begin
            reqSeen   = 1'b1;
            weSeen    = MEM_WE;
            addrSeen  = MEM_ADDR;
            wdataSeen = MEM_WDATA;
            if (PIPELINE_M !== '0) bubbleOk = 1'b0;
            for (int b = 1; b <= BUSY_LIMIT && !finished; b++) begin
                if (STALL) stallCycles++;
                if (b == ackDelay) begin
                    MEM_ACK   = 1'b1;
                    MEM_RDATA = rdata;
                end
                @(posedge CLK); #1;
                cycles++;
                MEM_ACK   = 1'b0;
                MEM_RDATA = $urandom();
                if (PIPELINE_M !== '0) bubbleOk = 1'b0;
                if (MEM_REQ) begin
                    if (MEM_WE !== weSeen || MEM_ADDR !== addrSeen || MEM_WDATA !== wdataSeen)
                        holdOk = 1'b0;
                end else begin
                    finished = 1'b1;
                end
            end
            if (finished) begin
                #1;
                if (STALL) stallCycles++;
                errSeen = MEM_ERR;
                @(posedge CLK); #1;
                cycles++;
            end
        end else begin
            finished = 1'b1;
            errSeen  = MEM_ERR;
        end
        pmOut = PIPELINE_M;
    endtask

    task automatic test_reset();
        exWord_t e;
        e          = randomWord();
        e.condOk   = 1'b1;
        e.memWrite = 1'b1;
        RST        = 1'b1;
        PIPELINE_E = e;
        MEM_ACK    = 1'b1;
        MEM_RDATA  = $urandom();
        @(posedge CLK); #1;
        nCompared++;
        if (STALL !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_stall: got %b expected 0", STALL);
        end
        @(posedge CLK); #1;
        nCompared++;
        if (PIPELINE_M !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_pm: got %h expected 0", PIPELINE_M);
        end
        nCompared++;
        if (MEM_REQ !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_req: got %b expected 0", MEM_REQ);
        end
        nCompared++;
        if (MEM_ERR !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_err: got %b expected 0", MEM_ERR);
        end
        nCompared++;
        if (STALL !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_stall2: got %b expected 0", STALL);
        end
        RST        = 1'b0;
        MEM_ACK    = 1'b0;
        PIPELINE_E = '0;
    endtask

    task automatic test_alu();
        exWord_t e;
        int sc, cy;
        logic rq, we, bo, ho, er, fin;
        logic [ADDR_W-1:0] ad;
        logic [31:0] wd;
        logic [111:0] pm;
        e         = '0;
        e.condOk  = 1'b1;
        e.regWrS  = 1'b1;
        e.sResult = 32'h0000_0010;
        e.dest    = 8'h05;
        runOp(e, 1, 32'h0, sc, cy, rq, we, ad, wd, bo, ho, pm, er, fin);
        nCompared++;
        if (pm[111] !== 1'b1 || pm[65:34] !== 32'h10 || pm[97:66] !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL alu_fields: got %h expected regWrS=1 s=10 load=0", pm);
        end
        nCompared++;
        if (pm !== expectM(e, 32'h0)) begin
            nMismatched++;
            $display("[TB] FAIL alu_pm: got %h expected %h", pm, expectM(e, 32'h0));
        end
        nCompared++;
        if (sc !== 0 || rq !== 1'b0 || cy !== 1) begin
            nMismatched++;
            $display("[TB] FAIL alu_timing: got stall=%0d req=%b cycles=%0d expected 0/0/1", sc, rq, cy);
        end
    endtask

    task automatic test_scalar_load();
        exWord_t e;
        int sc, cy;
        logic rq, we, bo, ho, er, fin;
        logic [ADDR_W-1:0] ad;
        logic [31:0] wd;
        logic [111:0] pm;
        e          = randomWord();
        e.condOk   = 1'b1;
        e.memWrite = 1'b0;
        e.memRead  = 1'b1;
        e.regWrS   = 1'b1;
        e.memToReg = 1'b1;
        e.sResult  = 32'h0000_0104;
        runOp(e, 3, 32'hCAFE_F00D, sc, cy, rq, we, ad, wd, bo, ho, pm, er, fin);
        nCompared++;
        if (rq !== 1'b1 || ad !== 16'h0041 || we !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL load_req: got req=%b addr=%h we=%b expected 1/0041/0", rq, ad, we);
        end
        nCompared++;
        if (sc !== 4 || cy !== 5 || fin !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL load_timing: got stall=%0d cycles=%0d done=%b expected 4/5/1", sc, cy, fin);
        end
        nCompared++;
        if (pm[97:66] !== 32'hCAFE_F00D || pm !== expectM(e, 32'hCAFE_F00D)) begin
            nMismatched++;
            $display("[TB] FAIL load_pm: got %h expected %h", pm, expectM(e, 32'hCAFE_F00D));
        end
        nCompared++;
        if (bo !== 1'b1 || ho !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL load_busy: got bubbles=%b hold=%b expected 1/1", bo, ho);
        end
    endtask

    task automatic test_vector_store();
        exWord_t e;
        int sc, cy;
        logic rq, we, bo, ho, er, fin;
        logic [ADDR_W-1:0] ad;
        logic [31:0] wd;
        logic [111:0] pm;
        e           = randomWord();
        e.condOk    = 1'b1;
        e.memWrite  = 1'b1;
        e.vecSel    = 1'b1;
        e.vResult   = 32'h1122_3344;
        e.storeData = 32'hFFFF_FFFF;
        runOp(e, 1, 32'hDEAD_BEEF, sc, cy, rq, we, ad, wd, bo, ho, pm, er, fin);
        nCompared++;
        if (rq !== 1'b1 || we !== 1'b1 || wd !== 32'h1122_3344) begin
            nMismatched++;
            $display("[TB] FAIL vstore_req: got req=%b we=%b wdata=%h expected 1/1/11223344", rq, we, wd);
        end
        nCompared++;
        if (cy !== 3 || sc !== 2) begin
            nMismatched++;
            $display("[TB] FAIL vstore_timing: got cycles=%0d stall=%0d expected 3/2", cy, sc);
        end
        nCompared++;
        if (pm[97:66] !== 32'h0 || pm !== expectM(e, 32'h0)) begin
            nMismatched++;
            $display("[TB] FAIL vstore_pm: got %h expected %h", pm, expectM(e, 32'h0));
        end
    endtask

    task automatic test_squash();
        exWord_t e;
        int sc, cy;
        logic rq, we, bo, ho, er, fin;
        logic [ADDR_W-1:0] ad;
        logic [31:0] wd;
        logic [111:0] pm;
        e          = randomWord();
        e.condOk   = 1'b0;
        e.memWrite = 1'b1;
        e.regWrS   = 1'b1;
        e.regWrV   = 1'b1;
        e.memToReg = 1'b1;
        runOp(e, 1, 32'h0, sc, cy, rq, we, ad, wd, bo, ho, pm, er, fin);
        nCompared++;
        if (rq !== 1'b0 || sc !== 0) begin
            nMismatched++;
            $display("[TB] FAIL squash_access: got req=%b stall=%0d expected 0/0", rq, sc);
        end
        nCompared++;
        if (pm[111:109] !== 3'b000 || pm !== expectM(e, 32'h0)) begin
            nMismatched++;
            $display("[TB] FAIL squash_pm: got %h expected %h", pm, expectM(e, 32'h0));
        end
    endtask

    task automatic test_ack_outside_busy();
        exWord_t e;
        e          = randomWord();
        e.condOk   = 1'b1;
        e.memWrite = 1'b0;
        e.memRead  = 1'b1;
        PIPELINE_E = e;
        MEM_ACK    = 1'b1;
        MEM_RDATA  = 32'h5555_AAAA;
        @(posedge CLK); #1;
        MEM_ACK = 1'b0;
        nCompared++;
        if (MEM_REQ !== 1'b1 || STALL !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL idle_ack: got req=%b stall=%b expected 1/1", MEM_REQ, STALL);
        end
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'h1234_5678;
        @(posedge CLK); #1;
        MEM_RDATA = 32'h9999_9999;
        @(posedge CLK); #1;
        MEM_ACK = 1'b0;
        nCompared++;
        if (PIPELINE_M !== expectM(e, 32'h1234_5678)) begin
            nMismatched++;
            $display("[TB] FAIL done_ack: got %h expected %h", PIPELINE_M, expectM(e, 32'h1234_5678));
        end
    endtask

    task automatic test_random_back_to_back();
        exWord_t e;
        int sc, cy, dly, expSc, expCy;
        logic rq, we, bo, ho, er, fin;
        logic [ADDR_W-1:0] ad;
        logic [31:0] wd, rd, expWd;
        logic [111:0] pm;
        for (int n = 0; n < 40; n++) begin
            e   = randomWord();
            dly = int'($urandom_range(1, 4));
            rd  = $urandom();
            runOp(e, dly, rd, sc, cy, rq, we, ad, wd, bo, ho, pm, er, fin);
            expSc = isMemOp(e) ? dly + 1 : 0;
            expCy = isMemOp(e) ? dly + 2 : 1;
            nCompared++;
            if (pm !== expectM(e, rd)) begin
                nMismatched++;
                $display("[TB] FAIL rand_pm[%0d]: got %h expected %h", n, pm, expectM(e, rd));
            end
            nCompared++;
            if (sc !== expSc || cy !== expCy || rq !== isMemOp(e) || fin !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL rand_timing[%0d]: got stall=%0d cycles=%0d req=%b expected %0d/%0d/%b",
                         n, sc, cy, rq, expSc, expCy, isMemOp(e));
            end
            if (isMemOp(e)) begin
                expWd = e.vecSel ? e.vResult : e.storeData;
                nCompared++;
                if (we !== e.memWrite || ad !== ADDR_W'(e.sResult / 4) || wd !== expWd ||
                    bo !== 1'b1 || ho !== 1'b1) begin
                    nMismatched++;
                    $display("[TB] FAIL rand_access[%0d]: got we=%b addr=%h wdata=%h bub=%b hold=%b expected %b/%h/%h/1/1",
                             n, we, ad, wd, bo, ho, e.memWrite, ADDR_W'(e.sResult / 4), expWd);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        exWord_t e, a;
        e          = randomWord();
        e.condOk   = 1'b1;
        e.memRead  = 1'b1;
        a          = randomWord();
        a.condOk   = 1'b1;
        a.memWrite = 1'b0;
        a.memRead  = 1'b0;
        PIPELINE_E = e;
        MEM_ACK    = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        nCompared++;
        if (MEM_REQ !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL midrst_busy: got req=%b expected 1", MEM_REQ);
        end
        RST = 1'b1;
        #1;
        nCompared++;
        if (STALL !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_stall: got %b expected 0", STALL);
        end
        @(posedge CLK); #1;
        nCompared++;
        if (MEM_REQ !== 1'b0 || PIPELINE_M !== '0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_clear: got req=%b pm=%h expected 0/0", MEM_REQ, PIPELINE_M);
        end
        RST        = 1'b0;
        PIPELINE_E = a;
        @(posedge CLK); #1;
        nCompared++;
        if (PIPELINE_M !== expectM(a, 32'h0) || MEM_REQ !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_idle: got pm=%h req=%b expected %h/0", PIPELINE_M, MEM_REQ, expectM(a, 32'h0));
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        exWord_t e;
        int sc, cy;
        logic rq, we, bo, ho, er, fin;
        logic [ADDR_W-1:0] ad;
        logic [31:0] wd;
        logic [111:0] pm;
        e          = randomWord();
        e.condOk   = 1'b1;
        e.memWrite = 1'b0;
        e.memRead  = 1'b1;
        runOp(e, 0, 32'h0, sc, cy, rq, we, ad, wd, bo, ho, pm, er, fin);
        nCompared++;
        if (fin !== 1'b1 || sc !== 5 || cy !== 6) begin
            nMismatched++;
            $display("[TB] FAIL timeout_timing: got done=%b stall=%0d cycles=%0d expected 1/5/6", fin, sc, cy);
        end
        nCompared++;
        if (er !== 1'b1 || pm !== expectM(e, 32'h0)) begin
            nMismatched++;
            $display("[TB] FAIL timeout_result: got err=%b pm=%h expected 1/%h", er, pm, expectM(e, 32'h0));
        end
        PIPELINE_E = '0;
        @(posedge CLK); #1;
        nCompared++;
        if (MEM_ERR !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL timeout_sticky: got %b expected 1", MEM_ERR);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        RST         = 1'b1;
        PIPELINE_E  = '0;
        MEM_ACK     = 1'b0;
        MEM_RDATA   = '0;
        test_reset();
        test_alu();
        test_scalar_load();
        test_vector_store();
        test_squash();
        test_ack_outside_busy();
        test_random_back_to_back();
        test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the 116-bit execute pipeline word and performs scalar or vector loads/stores to data memory over a req/ack handshake.
- Registers a 112-bit memory pipeline word toward writeback.
- Multi-cycle accesses are handled by an FSM that drives STALL so upstream stages freeze while an access is in flight.

Parameters:
ADDR_W, 16, word-address width of the data-memory port
TIMEOUT_CYCLES, 64, BUSY cycles without MEM_ACK before abort (only with MEM_TIMEOUT_EN)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
PIPELINE_E  in  116  execute word; field map below
PIPELINE_M  out  112  registered memory-stage word to writeback
STALL  out  1  combinational; 1 = upstream must hold PIPELINE_E stable
MEM_REQ  out  1  registered access request
MEM_WE  out  1  registered; 1 = store
MEM_ADDR  out  ADDR_W  registered word address
MEM_WDATA  out  32  registered store data
MEM_RDATA  in  32  load data, valid when MEM_ACK=1
MEM_ACK  in  1  access complete, one-cycle pulse
MEM_ERR  out  1  sticky timeout flag

Behaviour:
- PIPELINE_E fields:
  - [115] COND_OK
  - [114] MEM_WRITE
  - [113] MEM_READ
  - [112] VEC_SEL
  - [111] REG_WR_S
  - [110] REG_WR_V
  - [109] MEM_TO_REG
  - [108:106] WB_MISC
  - [105:98] DEST
  - [97:66] STORE_DATA
  - [65:34] S_RESULT
  - [33:32] PASS2
  - [31:0] V_RESULT
- PIPELINE_M fields:
  - {REG_WR_S, REG_WR_V, MEM_TO_REG, WB_MISC, DEST, LOAD_DATA[31:0], S_RESULT, PASS2, V_RESULT}
  - Bits [111:109] are the control bits.
- MEM_OP = COND_OK & (MEM_WRITE | MEM_READ).
- If MEM_WRITE and MEM_READ are both set, the access is treated as a store.
- COND_OK=0: instruction squashed.
  - No memory access.
  - PIPELINE_M control bits [111:109] = 0; other fields pass through.
- Address: MEM_ADDR = S_RESULT[ADDR_W+1:2]. Byte offset bits [1:0] are ignored.
- Store data: MEM_WDATA = VEC_SEL ? V_RESULT : STORE_DATA.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, !MEM_OP:
    - STALL=0.
    - PIPELINE_M <= mapped word, LOAD_DATA=0.
    - Latency 1 cycle.
  - IDLE, MEM_OP:
    - STALL=1; PIPELINE_M <= bubble (all 0).
    - Register MEM_REQ=1, MEM_WE, MEM_ADDR, MEM_WDATA; go to BUSY.
  - BUSY, MEM_ACK=0:
    - STALL=1; bubble out; MEM_REQ held at 1 with stable addr/data.
  - BUSY, MEM_ACK=1:
    - STALL=1; bubble out.
    - Capture MEM_RDATA into the load buffer (0 for stores).
    - MEM_REQ <= 0; go to DONE.
  - DONE:
    - STALL=0.
    - PIPELINE_M <= mapped word with LOAD_DATA = buffer.
    - Upstream advances at this edge; go to IDLE.
- Minimum cost of a memory op: 3 cycles (ACK in the first BUSY cycle).
- MEM_ACK outside BUSY is ignored.
- Reset values (RST=1 at any edge, including mid-access):
  - State IDLE.
  - PIPELINE_M = 0, MEM_REQ = MEM_WE = 0, MEM_ADDR = MEM_WDATA = 0, load buffer = 0, MEM_ERR = 0.
  - An abandoned request is dropped; memory must tolerate REQ falling without ACK.
- STALL is forced to 0 while RST=1.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Counter cleared on entering BUSY; increments each BUSY cycle without ACK.
  - On reaching TIMEOUT_CYCLES: MEM_REQ <= 0, load buffer <= 0, MEM_ERR <= 1 (sticky until RST), go to DONE.
  - ACK arriving in the same cycle as the timeout wins (normal completion, no error).
- MEM_TIMEOUT_EN undefined:
  - No counter; BUSY waits indefinitely.
  - MEM_ERR tied to 0.

Test Plan:
1. Reset held 2 cycles with garbage PIPELINE_E -> PIPELINE_M=0, MEM_REQ=0, STALL=0, MEM_ERR=0.
2. ALU-only word (COND_OK=1, REG_WR_S=1, S_RESULT=0x00000010) -> next edge PIPELINE_M[111]=1, S_RESULT field 0x10, LOAD_DATA=0, STALL never 1.
3. Scalar load, S_RESULT=0x00000104, MEM_ACK after 3 BUSY cycles with MEM_RDATA=0xCAFEF00D:
   - MEM_ADDR=0x0041, MEM_WE=0.
   - STALL high for 4 cycles.
   - PIPELINE_M LOAD_DATA=0xCAFEF00D in DONE.
4. Vector store, VEC_SEL=1, V_RESULT=0x11223344, STORE_DATA=0xFFFFFFFF:
   - MEM_WE=1, MEM_WDATA=0x11223344.
   - ACK in first BUSY cycle -> exactly 3-cycle op, LOAD_DATA=0.
5. Store with COND_OK=0 -> MEM_REQ stays 0, no stall, PIPELINE_M[111:109]=000.
6. RST asserted in BUSY -> next cycle MEM_REQ=0, state IDLE. With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4 and no ACK -> REQ drops after 4 BUSY cycles, MEM_ERR=1, LOAD_DATA=0.
